// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit.
// Holds the operand width, funct3 encodings and FSM state encoding.
package muldiv_pkg;
    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;
endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// hi/lo form the double-width product register, or remainder/quotient for divide.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] m,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);
    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        shifted = {hi, lo[XLEN-1]};
        // The partial remainder is always below the divisor, so a borrow
        // out of bit XLEN means the trial subtraction went negative.
        diff    = shifted - {1'b0, m};
        hi_next = sum[XLEN:1];
        lo_next = {sum[0], lo[XLEN-1:1]};
        if (is_div) begin
            if (diff[XLEN]) begin
                hi_next = shifted[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b0};
            end else begin
                hi_next = diff[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b1};
            end
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: operands are made unsigned on capture,
// iterated one bit per cycle, and the sign is restored in the FIX cycle.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    state_t            state;
    logic [2:0]        f3;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic [XLEN-1:0]   m;
    logic              neg;
    logic [CNT_W-1:0]  cnt;

    logic              a_neg, b_neg, is_div_in, special, ovf;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic [XLEN-1:0]   hi_next, lo_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

    always_comb begin
        is_div_in = funct3[2];
        a_neg     = op_a[XLEN-1] && (funct3 == F3_MUL || funct3 == F3_MULH ||
                    funct3 == F3_MULHSU || funct3 == F3_DIV || funct3 == F3_REM);
        b_neg     = op_b[XLEN-1] && (funct3 == F3_MUL || funct3 == F3_MULH ||
                    funct3 == F3_DIV || funct3 == F3_REM);
        a_abs     = a_neg ? -op_a : op_a;
        b_abs     = b_neg ? -op_b : op_b;
        ovf       = (funct3 == F3_DIV || funct3 == F3_REM) &&
                    op_a == {1'b1, {(XLEN-1){1'b0}}} && op_b == '1;
        special   = is_div_in && (op_b == '0 || ovf);
    end

    muldiv_step u_step (
        .is_div  (f3[2]),
        .hi      (hi),
        .lo      (lo),
        .m       (m),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    always_comb begin
        prod_fix = neg ? -{hi, lo} : {hi, lo};
        quo_fix  = neg ? -lo : lo;
        rem_fix  = neg ? -hi : hi;
        case (f3)
            F3_MUL:                        fix_val = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  fix_val = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               fix_val = quo_fix;
            default:                       fix_val = rem_fix;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            f3     <= '0;
            hi     <= '0;
            lo     <= '0;
            m      <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        f3   <= funct3;
                        cnt  <= '0;
                        busy <= 1'b1;
                        if (special) begin
                            // Preload quotient/remainder so FIX selects the
                            // architectural answer with no sign correction.
                            state <= S_FIX;
                            hi    <= ovf ? '0 : op_a;
                            lo    <= ovf ? {1'b1, {(XLEN-1){1'b0}}} : '1;
                            m     <= '0;
                            neg   <= 1'b0;
                        end else begin
                            state <= S_CALC;
                            hi    <= '0;
                            lo    <= is_div_in ? a_abs : b_abs;
                            m     <= is_div_in ? b_abs : a_abs;
                            neg   <= (funct3 == F3_REM) ? a_neg : (a_neg ^ b_neg);
                        end
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_CALC: begin
                    hi  <= hi_next;
                    lo  <= lo_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN-1)) state <= S_FIX;
                end
                S_FIX: begin
                    result <= fix_val;
                    state  <= S_DONE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
